// File: rtl/prog_mem_pkg.sv
// Shared definitions for the loadable program memory: default widths,
// the NOP opcode returned on out-of-range fetches, and the control states.
package prog_mem_pkg;

    localparam int BUS_WIDTH    = 8;
    localparam int OPCODE_WIDTH = 16;

    localparam logic [OPCODE_WIDTH-1:0] NOP_OPCODE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } prog_mem_state_t;

endpackage

// File: rtl/prog_mem_rsp_fifo.sv
// Two-entry response FIFO holding {instr, addr, err} fetch results.
// Payload storage is not reset; only the pointers and occupancy are.
module pm_rsp_fifo #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    input  logic [ADDR_WIDTH-1:0]  push_addr_i,
    input  logic                   push_err_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic [1:0]             count_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o,
    output logic [ADDR_WIDTH-1:0]  head_addr_o,
    output logic                   head_err_o
);

    logic [INSTR_WIDTH-1:0] instr_q [2];
    logic [ADDR_WIDTH-1:0]  addr_q  [2];
    logic [1:0]             err_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q;

    // Pointer and occupancy tracking; clear wins over any push/pop that cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    // Payload write at the tail slot.
    always_ff @(posedge clk) begin
        if (push_i) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            addr_q[wr_ptr_q]  <= push_addr_i;
            err_q[wr_ptr_q]   <= push_err_i;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = instr_q[rd_ptr_q];
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_err_o   = err_q[rd_ptr_q];

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory for the fetch stage. Words are written through the
// load port, then fetched with a valid/ready handshake. The synchronous read
// result sits in a one-deep in-flight stage that is presented directly when
// the response FIFO is empty, so a response is visible the cycle after accept.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = BUS_WIDTH,
    parameter int                     INSTR_WIDTH = OPCODE_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = NOP_OPCODE
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    output logic                   load_busy,
    output logic [ADDR_WIDTH:0]    prog_len,
    input  logic                   fetch_valid,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_ready,
    input  logic                   flush,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_WIDTH-1:0] rsp_instr,
    output logic [ADDR_WIDTH-1:0]  rsp_addr,
    output logic                   rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    prog_mem_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]    prog_len_q, prog_len_d;
    logic                   mem_we;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data_q;

    logic                   s1_vld_q;
    logic [ADDR_WIDTH-1:0]  s1_addr_q;
    logic                   s1_err_q;
    logic [INSTR_WIDTH-1:0] s1_instr;

    logic                   accept;
    logic                   leave_run;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_clear;
    logic                   fifo_empty;
    logic [1:0]             fifo_count;
    logic [INSTR_WIDTH-1:0] fifo_instr;
    logic [ADDR_WIDTH-1:0]  fifo_addr;
    logic                   fifo_err;

    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic                   head_err;

    assign leave_run   = (state_q == RUN) && load_start;
    assign fetch_ready = (state_q == RUN) && ((fifo_count + 2'(s1_vld_q)) < 2'd2);
    assign accept      = fetch_valid && fetch_ready;
    assign load_busy   = (state_q == LOAD);
    assign prog_len    = prog_len_q;

    // Load-mode sequencing: pointer advance, program length capture, mode changes.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        prog_len_d = prog_len_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                // A repeated load_start here is ignored on purpose.
                if (load_valid) begin
                    mem_we = 1'b1;
                    if (load_last) begin
                        state_d    = RUN;
                        prog_len_d = (ADDR_WIDTH+1)'(ptr_q) + (ADDR_WIDTH+1)'(1);
                    end else if (&ptr_q) begin
                        // Array full without a last marker: stop rather than wrap.
                        state_d    = RUN;
                        prog_len_d = (ADDR_WIDTH+1)'(DEPTH);
                    end else begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers for the load FSM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            prog_len_q <= prog_len_d;
        end
    end

    // Single write port (load) and single synchronous read port (fetch).
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= load_data;
        if (accept) rd_data_q <= mem[fetch_addr];
    end

    // In-flight stage: the previous occupant always moves on, so validity
    // simply follows this cycle's accept unless the block is leaving RUN.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_err_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept && !leave_run;
            if (accept) begin
                s1_addr_q <= fetch_addr;
                s1_err_q  <= ({1'b0, fetch_addr} >= prog_len_q);
            end
        end
    end

    assign s1_instr   = s1_err_q ? NOP_WORD : rd_data_q;
    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_clear = flush || leave_run;
    assign fifo_pop   = !fifo_empty && rsp_ready;
    // The in-flight entry bypasses the FIFO when it is the head and is taken now.
    assign fifo_push  = s1_vld_q && !(fifo_empty && rsp_ready);

    pm_rsp_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_rsp_fifo (
        .clk          (clk),
        .n_rst        (n_rst),
        .push_i       (fifo_push),
        .push_instr_i (s1_instr),
        .push_addr_i  (s1_addr_q),
        .push_err_i   (s1_err_q),
        .pop_i        (fifo_pop),
        .clear_i      (fifo_clear),
        .count_o      (fifo_count),
        .head_instr_o (fifo_instr),
        .head_addr_o  (fifo_addr),
        .head_err_o   (fifo_err)
    );

    assign head_instr = fifo_empty ? s1_instr  : fifo_instr;
    assign head_addr  = fifo_empty ? s1_addr_q : fifo_addr;
    assign head_err   = fifo_empty ? s1_err_q  : fifo_err;

    assign rsp_valid = !fifo_empty || s1_vld_q;
    assign rsp_instr = rsp_valid ? head_instr : '0;
    assign rsp_addr  = rsp_valid ? head_addr  : '0;
    assign rsp_err   = rsp_valid && head_err;

endmodule
